qspi_sram_responder: RTL and testbench

//  Synthesizable responder (slave) model of a 23LC1024-style serial SRAM in SQI mode.

---
 rtl/qspi_sram_responder_pkg.sv | 22 ++
 rtl/qspi_sram_byte_mem.sv | 24 ++
 rtl/qspi_sram_responder.sv | 179 +++++++++++++++++
 tb/tb_qspi_sram_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_sram_responder_pkg.sv
// Shared command codes and FSM encoding for the QSPI SRAM responder.
// Pure declarations, no timing; no flow control.
// The SoC initiator encoders use the same command values.
package qspi_sram_responder_pkg;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_EQIO   = 8'h38;
    localparam logic [7:0] CMD_RSTQIO = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPI_CMD,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_READ,
        ST_WRITE,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/qspi_sram_byte_mem.sv
// Single-port byte array, synchronous write, combinational read at addr.
// Write lands on the clk edge with we=1; read data follows addr in the same cycle.
// No backpressure; contents are deliberately not reset.
module qspi_sram_byte_mem #(
    parameter int ADDRESS_WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata
);

    logic [7:0] mem [0:(1 << ADDRESS_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/qspi_sram_responder.sv
// 23LC1024-style serial SRAM responder: SPI EQIO, SQI READ/WRITE/RSTQIO, sequential addressing.
// Inputs sampled in the sck rise cycle; READ nibbles valid one clk after the fall is detected.
// No backpressure: the initiator paces everything through sram_sck and sram_cs_n.
module qspi_sram_responder
    import qspi_sram_responder_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 17,
    parameter int DUMMY_NIBBLES = 2,
    parameter bit START_IN_QUAD = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sram_cs_n,
    input  logic sram_sck,
    input  logic sram_sio0_i,
    input  logic sram_sio1_i,
    input  logic sram_sio2_i,
    input  logic sram_sio3_i,
    output logic sram_sio0_o,
    output logic sram_sio1_o,
    output logic sram_sio2_o,
    output logic sram_sio3_o,
    output logic sram_sio_oe,
    output logic quad_mode
);

    state_t                   state_q, state_d;
    logic                     sck_q;
    logic [2:0]               cnt_q, cnt_d;
    logic [7:0]               sr_q, sr_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]               hi_q, hi_d;
    logic                     quad_q, quad_d;
    logic [3:0]               sio_q, sio_d;
    logic                     oe_q, oe_d;
    logic                     mem_we;
    logic [7:0]               mem_rdata;

    logic                     rise, fall;
    logic [3:0]               nib;
    logic [7:0]               cmd_byte, spi_byte;
    logic [ADDRESS_WIDTH-1:0] addr_inc;

    assign rise     = sram_sck & ~sck_q;
    assign fall     = ~sram_sck & sck_q;
    assign nib      = {sram_sio3_i, sram_sio2_i, sram_sio1_i, sram_sio0_i};
    assign cmd_byte = {sr_q[3:0], nib};
    assign spi_byte = {sr_q[6:0], sram_sio0_i};
    assign addr_inc = addr_q + 1'b1;

    qspi_sram_byte_mem #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr_q),
        .wdata ({hi_q, nib}),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sck_q   <= 1'b0;
            cnt_q   <= '0;
            sr_q    <= '0;
            addr_q  <= '0;
            hi_q    <= '0;
            quad_q  <= START_IN_QUAD;
            sio_q   <= '0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sck_q   <= sram_sck;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            addr_q  <= addr_d;
            hi_q    <= hi_d;
            quad_q  <= quad_d;
            sio_q   <= sio_d;
            oe_q    <= oe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        addr_d  = addr_q;
        hi_d    = hi_q;
        quad_d  = quad_q;
        sio_d   = sio_q;
        oe_d    = oe_q;
        mem_we  = 1'b0;
        if (sram_cs_n) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sio_d   = '0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (rise) begin
                    cnt_d = 3'd1;
                    if (quad_q) begin
                        sr_d    = {4'h0, nib};
                        state_d = ST_CMD;
                    end else begin
                        sr_d    = {7'h0, sram_sio0_i};
                        state_d = ST_SPI_CMD;
                    end
                end
                ST_SPI_CMD: if (rise) begin
                    sr_d  = spi_byte;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = ST_IGNORE;
                        if (spi_byte == CMD_EQIO) quad_d = 1'b1;
                    end
                end
                ST_CMD: if (rise) begin
                    sr_d  = cmd_byte;
                    cnt_d = '0;
                    if (cmd_byte == CMD_READ || cmd_byte == CMD_WRITE) begin
                        state_d = ST_ADDR;
                    end else begin
                        state_d = ST_IGNORE;
                        if (cmd_byte == CMD_RSTQIO) quad_d = 1'b0;
                    end
                end
                // Only the low ADDRESS_WIDTH bits survive the shift.
                ST_ADDR: if (rise) begin
                    addr_d = ADDRESS_WIDTH'({addr_q, nib});
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == 3'd5) begin
                        cnt_d   = '0;
                        state_d = (sr_q == CMD_READ) ? ST_DUMMY : ST_WRITE;
                    end
                end
                // Count dummy rises; the fall after the last one drives data.
                ST_DUMMY: begin
                    if (rise) begin
                        cnt_d = cnt_q + 3'd1;
                    end else if (fall && cnt_q == 3'(DUMMY_NIBBLES)) begin
                        state_d = ST_READ;
                        sio_d   = mem_rdata[7:4];
                        oe_d    = 1'b1;
                        cnt_d   = 3'd1;
                    end
                end
                // cnt_q[0] marks the low nibble as next in READ and WRITE.
                ST_READ: if (fall) begin
                    if (cnt_q[0]) begin
                        sio_d  = mem_rdata[3:0];
                        addr_d = addr_inc;
                        cnt_d  = '0;
                    end else begin
                        sio_d  = mem_rdata[7:4];
                        cnt_d  = 3'd1;
                    end
                end
                ST_WRITE: if (rise) begin
                    if (cnt_q[0]) begin
                        mem_we = 1'b1;
                        addr_d = addr_inc;
                        cnt_d  = '0;
                    end else begin
                        hi_d   = nib;
                        cnt_d  = 3'd1;
                    end
                end
                ST_IGNORE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign {sram_sio3_o, sram_sio2_o, sram_sio1_o, sram_sio0_o} = sio_q;
    assign sram_sio_oe = oe_q;
    assign quad_mode   = quad_q;

endmodule

// File: tb/tb_qspi_sram_responder.sv
// Scoreboarded bench for qspi_sram_responder: directed SPI/SQI transactions,
// expected READ nibbles queued at issue time and popped on each initiator sampling edge.
module tb_qspi_sram_responder;
    import qspi_sram_responder_pkg::*;

    localparam int DUMMY = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       sram_cs_n;
    logic       sram_sck;
    logic [3:0] sio_i;
    logic       sio0_o, sio1_o, sio2_o, sio3_o;
    logic       sram_sio_oe;
    logic       quad_mode;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] exp_q[$];

    qspi_sram_responder #(
        .ADDRESS_WIDTH (17),
        .DUMMY_NIBBLES (DUMMY),
        .START_IN_QUAD (1'b0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sram_cs_n   (sram_cs_n),
        .sram_sck    (sram_sck),
        .sram_sio0_i (sio_i[0]),
        .sram_sio1_i (sio_i[1]),
        .sram_sio2_i (sio_i[2]),
        .sram_sio3_i (sio_i[3]),
        .sram_sio0_o (sio0_o),
        .sram_sio1_o (sio1_o),
        .sram_sio2_o (sio2_o),
        .sram_sio3_o (sio3_o),
        .sram_sio_oe (sram_sio_oe),
        .quad_mode   (quad_mode)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: the initiator samples READ data on its sck rise.
    always @(posedge sram_sck) begin
        logic [3:0] got;
        got = {sio3_o, sio2_o, sio1_o, sio0_o};
        if (sram_sio_oe === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_unexpected: got %0h with no expected nibble", got);
            end else begin
                check_val("rd_nibble", 32'(got), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        exp_q.push_back(b[7:4]);
        exp_q.push_back(b[3:0]);
    endtask

    task automatic send_nib(input logic [3:0] n);
        @(negedge clk);
        sio_i    = n;
        sram_sck = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sram_sck = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_nib(b[7:4]);
        send_nib(b[3:0]);
    endtask

    task automatic send_addr(input logic [23:0] a);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic cs_lo();
        @(negedge clk);
        sram_cs_n = 1'b0;
    endtask

    task automatic cs_hi();
        @(negedge clk);
        sram_cs_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic spi_cmd(input logic [7:0] b);
        cs_lo();
        for (int i = 7; i >= 0; i--) send_nib({3'b000, b[i]});
        cs_hi();
    endtask

    task automatic sqi_write(input logic [23:0] a, input logic [15:0] d, input int nbytes);
        cs_lo();
        send_byte(CMD_WRITE);
        send_addr(a);
        send_byte(d[15:8]);
        if (nbytes > 1) send_byte(d[7:0]);
        cs_hi();
    endtask

    task automatic sqi_read(input logic [23:0] a, input int nbytes);
        cs_lo();
        send_byte(CMD_READ);
        send_addr(a);
        repeat (DUMMY) send_nib(4'h0);
        repeat (2 * nbytes) send_nib(4'h0);
        cs_hi();
        check_val("rd_drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        sram_cs_n = 1'b1;
        sram_sck  = 1'b0;
        sio_i     = 4'h0;
        repeat (3) @(negedge clk);
        check_val("rst_oe", 32'(sram_sio_oe), 32'd0);
        check_val("rst_sio", 32'({sio3_o, sio2_o, sio1_o, sio0_o}), 32'd0);
        check_val("rst_quad", 32'(quad_mode), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // SPI EQIO: mode flips only with the 8th bit.
        begin
            logic [7:0] eqio;
            eqio = CMD_EQIO;
            cs_lo();
            for (int i = 7; i >= 1; i--) send_nib({3'b000, eqio[i]});
            check_val("eqio_7bits_quad", 32'(quad_mode), 32'd0);
            send_nib({3'b000, eqio[0]});
            check_val("eqio_quad", 32'(quad_mode), 32'd1);
            check_val("eqio_oe", 32'(sram_sio_oe), 32'd0);
            cs_hi();
        end

        // Write/read back BE EF at 0x10.
        sqi_write(24'h000010, 16'hBEEF, 2);
        push_byte(8'hBE); push_byte(8'hEF);
        sqi_read(24'h000010, 2);

        // Address wrap at the top of the 17-bit space.
        sqi_write(24'h01FFFF, 16'hA55A, 2);
        push_byte(8'hA5); push_byte(8'h5A);
        sqi_read(24'h01FFFF, 2);
        push_byte(8'h5A);
        sqi_read(24'h000000, 1);
        // Upper address bits are ignored: 0x020010 aliases 0x10.
        push_byte(8'hBE);
        sqi_read(24'h020010, 1);

        // Lone high nibble is discarded; next chip select decodes a fresh command.
        sqi_write(24'h000020, 16'h3C00, 1);
        cs_lo();
        send_byte(CMD_WRITE);
        send_addr(24'h000020);
        send_nib(4'h7);
        cs_hi();
        push_byte(8'h3C);
        sqi_read(24'h000020, 1);

        // Reset in the middle of a READ.
        exp_q.push_back(4'hB);
        cs_lo();
        send_byte(CMD_READ);
        send_addr(24'h000010);
        repeat (DUMMY) send_nib(4'h0);
        send_nib(4'h0);
        check_val("midrd_oe", 32'(sram_sio_oe), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("midrd_rst_oe", 32'(sram_sio_oe), 32'd0);
        check_val("midrd_rst_sio", 32'({sio3_o, sio2_o, sio1_o, sio0_o}), 32'd0);
        check_val("midrd_rst_quad", 32'(quad_mode), 32'd0);
        check_val("midrd_drain", 32'(exp_q.size()), 32'd0);
        sram_cs_n = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        spi_cmd(CMD_EQIO);
        check_val("re_eqio_quad", 32'(quad_mode), 32'd1);
        push_byte(8'hBE); push_byte(8'hEF);
        sqi_read(24'h000010, 2);

        // RSTQIO back to SPI, then re-enter quad mode.
        cs_lo();
        send_byte(CMD_RSTQIO);
        check_val("rstqio_quad", 32'(quad_mode), 32'd0);
        cs_hi();
        spi_cmd(CMD_EQIO);

        // Unsupported command with write-like payload must not touch memory.
        cs_lo();
        send_byte(8'h9F);
        send_addr(24'h000010);
        send_byte(8'h12);
        check_val("unsup_oe", 32'(sram_sio_oe), 32'd0);
        check_val("unsup_quad", 32'(quad_mode), 32'd1);
        cs_hi();
        push_byte(8'hBE);
        sqi_read(24'h000010, 1);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
